// File: rtl/asteroids_pkg.sv
// Shared asteroids types: slot state, heading encoding, screen size and heading-to-step-sign lookup.
// Pure declarations, no logic or latency.
package asteroids_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   typedef enum logic {
      IDLE   = 1'b0,
      FLYING = 1'b1
   } slot_state_t;

   typedef enum logic [2:0] {
      DIR_UP    = 3'd0,
      DIR_UR    = 3'd1,
      DIR_RIGHT = 3'd2,
      DIR_DR    = 3'd3,
      DIR_DOWN  = 3'd4,
      DIR_DL    = 3'd5,
      DIR_LEFT  = 3'd6,
      DIR_UL    = 3'd7
   } dir_t;

   typedef struct packed {
      logic signed [1:0] sx;
      logic signed [1:0] sy;
   } dir_sign_t;

   // Screen y grows downward, so "up" is a negative y step.
   function automatic dir_sign_t dir_sign(input logic [2:0] dir);
      dir_sign_t s;
      s.sx = 2'sd0;
      s.sy = 2'sd0;
      case (dir_t'(dir))
         DIR_UP:    s.sy = -2'sd1;
         DIR_UR:    begin s.sx =  2'sd1; s.sy = -2'sd1; end
         DIR_RIGHT: s.sx =  2'sd1;
         DIR_DR:    begin s.sx =  2'sd1; s.sy =  2'sd1; end
         DIR_DOWN:  s.sy =  2'sd1;
         DIR_DL:    begin s.sx = -2'sd1; s.sy =  2'sd1; end
         DIR_LEFT:  s.sx = -2'sd1;
         DIR_UL:    begin s.sx = -2'sd1; s.sy = -2'sd1; end
         default:   s.sx = 2'sd0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bullet_controller_if.sv
// Ship/raster/collision bundle of the bullet controller; master drives inputs, slave is the controller.
// No latency of its own; there is no backpressure on any of these signals.
interface bullet_controller_if #(parameter int NUM_BULLETS = 4);
   logic                   frame_tick;
   logic                   fire;
   logic [9:0]             ship_x;
   logic [9:0]             ship_y;
   logic [2:0]             ship_dir;
   logic [9:0]             px;
   logic [9:0]             py;
   logic [NUM_BULLETS-1:0] kill;
   logic [NUM_BULLETS-1:0] bullet_pix;
   logic [NUM_BULLETS-1:0] active;
   logic [15:0]            shots_fired;

   modport master (
      output frame_tick, fire, ship_x, ship_y, ship_dir, px, py, kill,
      input  bullet_pix, active, shots_fired
   );

   modport slave (
      input  frame_tick, fire, ship_x, ship_y, ship_dir, px, py, kill,
      output bullet_pix, active, shots_fired
   );
endinterface

// File: rtl/bullet_slot.sv
// One bullet: IDLE/FLYING FSM, per-frame move, retire and registered pixel compare (1 clk late).
// No backpressure; BULLET_WRAP_EN makes screen exits wrap instead of retiring.
module bullet_slot
   import asteroids_pkg::*;
#(
   parameter int SPEED    = 4,
   parameter int LIFETIME = 60,
   parameter int SIZE     = 2
) (
   input  logic       clk,
   input  logic       reset_game,
   input  logic       frame_tick,
   input  logic       kill,
   input  logic       spawn,
   input  logic [9:0] spawn_x,
   input  logic [9:0] spawn_y,
   input  logic [2:0] spawn_dir,
   input  logic [9:0] px,
   input  logic [9:0] py,
   output logic       active,
   output logic       pix
);
   localparam int LW = $clog2(LIFETIME + 1);
   localparam logic signed [10:0] STEP = 11'(SPEED);
   localparam logic signed [10:0] XMAX = 11'(H_ACTIVE - 1);
   localparam logic signed [10:0] YMAX = 11'(V_ACTIVE - 1);

   slot_state_t       state, state_n;
   logic [9:0]        x, y, x_n, y_n, wx, wy;
   logic [2:0]        dir, dir_n;
   logic [LW-1:0]     life, life_n, life_dec;
   logic signed [10:0] dx, dy, nx, ny;
   dir_sign_t         sgn;
   logic              exit_x, exit_y, retire;
   logic              hit_x, hit_y;

   always_comb begin
      sgn      = dir_sign(dir);
      dx       = (sgn.sx == 2'sd1) ? STEP : (sgn.sx == -2'sd1) ? -STEP : 11'sd0;
      dy       = (sgn.sy == 2'sd1) ? STEP : (sgn.sy == -2'sd1) ? -STEP : 11'sd0;
      nx       = $signed({1'b0, x}) + dx;
      ny       = $signed({1'b0, y}) + dy;
      exit_x   = nx[10] || (nx > XMAX);
      exit_y   = ny[10] || (ny > YMAX);
      life_dec = life - LW'(1);
`ifdef BULLET_WRAP_EN
      // One step is far smaller than the screen, so a single add/sub wraps.
      wx     = exit_x ? (nx[10] ? 10'(nx + 11'(H_ACTIVE)) : 10'(nx - 11'(H_ACTIVE))) : nx[9:0];
      wy     = exit_y ? (ny[10] ? 10'(ny + 11'(V_ACTIVE)) : 10'(ny - 11'(V_ACTIVE))) : ny[9:0];
      retire = (life_dec == '0);
`else
      wx     = nx[9:0];
      wy     = ny[9:0];
      retire = (life_dec == '0) || exit_x || exit_y;
`endif
   end

   always_comb begin
      state_n = state;
      x_n     = x;
      y_n     = y;
      dir_n   = dir;
      life_n  = life;
      case (state)
         IDLE: begin
            if (spawn && !kill) begin
               state_n = FLYING;
               x_n     = spawn_x;
               y_n     = spawn_y;
               dir_n   = spawn_dir;
               life_n  = LW'(LIFETIME);
            end
         end
         FLYING: begin
            if (kill) begin
               state_n = IDLE;
            end else if (frame_tick) begin
               x_n    = wx;
               y_n    = wy;
               life_n = life_dec;
               if (retire) state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign hit_x  = ({1'b0, px} >= {1'b0, x}) && ({1'b0, px} < ({1'b0, x} + 11'(SIZE)));
   assign hit_y  = ({1'b0, py} >= {1'b0, y}) && ({1'b0, py} < ({1'b0, y} + 11'(SIZE)));
   assign active = (state == FLYING);

   always_ff @(posedge clk or posedge reset_game) begin
      if (reset_game) begin
         state <= IDLE;
         x     <= '0;
         y     <= '0;
         dir   <= '0;
         life  <= '0;
         pix   <= 1'b0;
      end else begin
         state <= state_n;
         x     <= x_n;
         y     <= y_n;
         dir   <= dir_n;
         life  <= life_n;
         // Gate with next state so a kill blanks the pixel on the same edge.
         pix   <= (state_n == FLYING) && hit_x && hit_y;
      end
   end

endmodule

// File: rtl/bullet_controller.sv
// Ship bullet manager: fire sync (3 clk to pending), cooldown, lowest-free-slot spawn on frame_tick, shot count.
// No backpressure: a fire with no free slot stays pending; BULLET_WRAP_EN selects wrap-around in bullet_slot.
module bullet_controller
   import asteroids_pkg::*;
#(
   parameter int NUM_BULLETS = 4,
   parameter int SPEED       = 4,
   parameter int LIFETIME    = 60,
   parameter int COOLDOWN    = 8,
   parameter int SIZE        = 2
) (
   input  logic               clk,
   input  logic               reset_game,
   bullet_controller_if.slave bus
);
   localparam int CW = $clog2(COOLDOWN + 1);

   logic                   fire_sync1, fire_sync2, fire_prev, rise;
   logic                   pending;
   logic [CW-1:0]          cooldown, cooldown_n;
   logic [NUM_BULLETS-1:0] free, spawn_vec, active_vec, pix_vec;
   logic                   found, spawn_go;
   logic [15:0]            shots;

   assign rise = fire_sync2 && !fire_prev;

   always_comb begin
      cooldown_n = cooldown;
      if (bus.frame_tick && (cooldown != '0)) cooldown_n = cooldown - CW'(1);
      // Killed slots are excluded so a kill always wins over a spawn into it.
      free      = ~active_vec & ~bus.kill;
      spawn_vec = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (free[i] && !found) begin
            spawn_vec[i] = 1'b1;
            found        = 1'b1;
         end
      end
      spawn_go = bus.frame_tick && pending && (cooldown_n == '0) && found;
      if (!spawn_go) spawn_vec = '0;
   end

   always_ff @(posedge clk or posedge reset_game) begin
      if (reset_game) begin
         fire_sync1 <= 1'b0;
         fire_sync2 <= 1'b0;
         fire_prev  <= 1'b0;
         pending    <= 1'b0;
         cooldown   <= '0;
         shots      <= '0;
      end else begin
         fire_sync1 <= bus.fire;
         fire_sync2 <= fire_sync1;
         fire_prev  <= fire_sync2;
         pending    <= spawn_go ? 1'b0 : (pending || rise);
         cooldown   <= spawn_go ? CW'(COOLDOWN) : cooldown_n;
         shots      <= shots + 16'(spawn_go);
      end
   end

   for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
      bullet_slot #(
         .SPEED    (SPEED),
         .LIFETIME (LIFETIME),
         .SIZE     (SIZE)
      ) u_slot (
         .clk        (clk),
         .reset_game (reset_game),
         .frame_tick (bus.frame_tick),
         .kill       (bus.kill[g]),
         .spawn      (spawn_vec[g]),
         .spawn_x    (bus.ship_x),
         .spawn_y    (bus.ship_y),
         .spawn_dir  (bus.ship_dir),
         .px         (bus.px),
         .py         (bus.py),
         .active     (active_vec[g]),
         .pix        (pix_vec[g])
      );
   end

   assign bus.active      = active_vec;
   assign bus.bullet_pix  = pix_vec;
   assign bus.shots_fired = shots;

endmodule

// File: tb/tb_bullet_controller.sv
// Bench for bullet_controller: directed sequences, a probe table and a random run against a frame-level model.
// Honours BULLET_WRAP_EN the same way as the design build.
module tb_bullet_controller;
   import asteroids_pkg::*;

   localparam int NB = 4, SPEED = 4, LIFETIME = 60, COOLDOWN = 8, SIZE = 2;

   logic clk = 1'b0;
   logic reset_game;
   always #5 clk = ~clk;

   bullet_controller_if #(.NUM_BULLETS(NB)) bus();

   bullet_controller #(
      .NUM_BULLETS(NB), .SPEED(SPEED), .LIFETIME(LIFETIME), .COOLDOWN(COOLDOWN), .SIZE(SIZE)
   ) dut (
      .clk        (clk),
      .reset_game (reset_game),
      .bus        (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: bullets as integer records, fire edge seen 3 clk after it happens.
   int  mx[NB], my[NB], mdir[NB], mlife[NB];
   bit  mfly[NB];
   bit  mpend;
   int  mcd, mshots;
   bit  f1, f2, f3;
   logic [NB-1:0] mpix;
   bit  pix_valid;

   typedef struct {
      int px;
      int py;
      bit pix;
   } probe_t;
   probe_t probes[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sgnx(input int d);
      if (d >= 1 && d <= 3) return 1;
      if (d >= 5 && d <= 7) return -1;
      return 0;
   endfunction

   function automatic int sgny(input int d);
      if (d >= 3 && d <= 5) return 1;
      if (d == 0 || d == 1 || d == 7) return -1;
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         mx[i] = 0; my[i] = 0; mdir[i] = 0; mlife[i] = 0; mfly[i] = 0;
      end
      mpend = 0; mcd = 0; mshots = 0;
      f1 = 0; f2 = 0; f3 = 0;
      mpix = '0; pix_valid = 1;
   endtask

   task automatic model_edge();
      bit rise, spawned, tk;
      bit was_fly[NB];
      int nx, ny;
      rise    = f2 & ~f3;
      spawned = 0;
      tk      = bus.frame_tick;
      for (int i = 0; i < NB; i++) was_fly[i] = mfly[i];
      for (int i = 0; i < NB; i++) begin
         if (mfly[i] && bus.kill[i]) begin
            mfly[i] = 0;
         end else if (mfly[i] && tk) begin
            nx = mx[i] + SPEED * sgnx(mdir[i]);
            ny = my[i] + SPEED * sgny(mdir[i]);
            mlife[i]--;
`ifdef BULLET_WRAP_EN
            nx = ((nx % H_ACTIVE) + H_ACTIVE) % H_ACTIVE;
            ny = ((ny % V_ACTIVE) + V_ACTIVE) % V_ACTIVE;
            mfly[i] = (mlife[i] != 0);
`else
            mfly[i] = (mlife[i] != 0) && nx >= 0 && nx < H_ACTIVE && ny >= 0 && ny < V_ACTIVE;
`endif
            mx[i] = nx; my[i] = ny;
         end
      end
      if (tk) begin
         if (mcd > 0) mcd--;
         if (mpend && mcd == 0) begin
            for (int i = 0; i < NB; i++) begin
               if (!spawned && !was_fly[i] && !bus.kill[i]) begin
                  mfly[i] = 1; mx[i] = int'(bus.ship_x); my[i] = int'(bus.ship_y);
                  mdir[i] = int'(bus.ship_dir); mlife[i] = LIFETIME;
                  mcd = COOLDOWN; mshots = (mshots + 1) % 65536;
                  spawned = 1;
               end
            end
         end
      end
      mpend = spawned ? 1'b0 : (mpend | rise);
      f3 = f2; f2 = f1; f1 = bus.fire;
      for (int i = 0; i < NB; i++)
         mpix[i] = mfly[i] && int'(bus.px) >= mx[i] && int'(bus.px) < mx[i] + SIZE &&
                   int'(bus.py) >= my[i] && int'(bus.py) < my[i] + SIZE;
      // Positions move on the tick edge itself; the pixel is only defined on quiet cycles.
      pix_valid = !tk;
   endtask

   task automatic model_check();
      logic [NB-1:0] ma;
      for (int i = 0; i < NB; i++) ma[i] = mfly[i];
      chk("model_active", 32'(bus.active), 32'(ma));
      chk("model_shots", 32'(bus.shots_fired), 32'(mshots));
      if (pix_valid) chk("model_pix", 32'(bus.bullet_pix), 32'(mpix));
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
      model_check();
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic frame(input bit f, input logic [NB-1:0] k);
      if (f) begin
         bus.fire = 1'b1; idle(4);
         bus.fire = 1'b0; idle(4);
      end else begin
         idle(2);
      end
      bus.kill = k;
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
      bus.kill = '0;
   endtask

   task automatic do_reset();
      reset_game     = 1'b1;
      bus.frame_tick = 1'b0; bus.fire = 1'b0; bus.kill = '0;
      bus.px = '0; bus.py = '0;
      #1;
      chk("reset_active", 32'(bus.active), 32'd0);
      chk("reset_pix", 32'(bus.bullet_pix), 32'd0);
      chk("reset_shots", 32'(bus.shots_fired), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_game = 1'b0;
      model_reset();
   endtask

   initial begin
      int n, cnt, prev;
      int sp[$];
      logic [23:0] spv;

      reset_game = 1'b1;
      bus.ship_x = '0; bus.ship_y = '0; bus.ship_dir = '0;
      model_reset();

      // Spawn and move right.
      do_reset();
      bus.ship_x = 10'd100; bus.ship_y = 10'd200; bus.ship_dir = 3'd2;
      frame(1, '0);
      chk("spawn_active", 32'(bus.active), 32'h1);
      chk("spawn_shots", 32'(bus.shots_fired), 32'd1);
      bus.px = 10'd100; bus.py = 10'd200; idle(1);
      chk("spawn_pos", 32'(bus.bullet_pix[0]), 32'd1);
      repeat (5) frame(0, '0);
      bus.px = 10'd120; bus.py = 10'd200; idle(1);
      chk("move_x120", 32'(bus.bullet_pix[0]), 32'd1);
      bus.px = 10'd119; idle(1);
      chk("move_x119", 32'(bus.bullet_pix[0]), 32'd0);

      // Rate limit.
      do_reset();
      bus.ship_x = 10'd320; bus.ship_y = 10'd240; bus.ship_dir = 3'd4;
      prev = 0;
      for (int t = 1; t <= 20; t++) begin
         frame(1, '0);
         if (int'(bus.shots_fired) != prev) sp.push_back(t);
         prev = int'(bus.shots_fired);
      end
      spv = (sp.size() == 3) ? {8'(sp[0]), 8'(sp[1]), 8'(sp[2])} : 24'(sp.size());
      chk("rate_ticks", 32'(spv), 32'h010911);
      chk("rate_active", 32'(bus.active), 32'h7);
      chk("rate_shots", 32'(bus.shots_fired), 32'd3);

      // Exhaustion: fifth shot waits for a kill.
      do_reset();
      bus.ship_dir = 3'd0;
      for (int t = 1; t <= 33; t++) frame(1, '0);
      chk("exh_full", 32'(bus.active), 32'hF);
      chk("exh_held", 32'(bus.shots_fired), 32'd4);
      bus.kill = 4'b0001; idle(1); bus.kill = '0;
      chk("exh_kill", 32'(bus.active), 32'hE);
      frame(0, '0);
      chk("exh_respawn", 32'(bus.active), 32'hF);
      chk("exh_shots", 32'(bus.shots_fired), 32'd5);

      // Kill on the spawn tick steers the spawn to slot 1.
      do_reset();
      bus.ship_dir = 3'd2;
      frame(1, '0);
      for (int t = 2; t <= 9; t++) frame(1, (t == 9) ? 4'b0001 : 4'b0000);
      chk("killspawn_active", 32'(bus.active), 32'h2);
      chk("killspawn_shots", 32'(bus.shots_fired), 32'd2);

      // Lifetime / top exit.
      do_reset();
      bus.ship_x = 10'd320; bus.ship_y = 10'd20; bus.ship_dir = 3'd0;
      frame(1, '0);
      n = 0;
      for (int k = 0; k < 70; k++) begin
         frame(0, '0);
         n++;
`ifdef BULLET_WRAP_EN
         if (n == 6) begin
            bus.px = 10'd320; bus.py = 10'd476; idle(1);
            chk("wrap_y476", 32'(bus.bullet_pix[0]), 32'd1);
         end
`endif
         if (!bus.active[0]) break;
      end
`ifdef BULLET_WRAP_EN
      chk("life_ticks", 32'(n), 32'd60);
`else
      chk("exit_ticks", 32'(n), 32'd6);
`endif

      // Render at (300,300): probe table, lag, window count.
      do_reset();
      bus.ship_x = 10'd300; bus.ship_y = 10'd300; bus.ship_dir = 3'd0;
      probes[0] = '{300, 300, 1}; probes[1] = '{301, 300, 1};
      probes[2] = '{300, 301, 1}; probes[3] = '{301, 301, 1};
      probes[4] = '{299, 300, 0}; probes[5] = '{302, 300, 0};
      probes[6] = '{300, 299, 0}; probes[7] = '{300, 302, 0};
      probes[8] = '{302, 302, 0}; probes[9] = '{0, 0, 0};
      frame(1, '0);
      for (int i = 0; i < 10; i++) begin
         bus.px = 10'(probes[i].px); bus.py = 10'(probes[i].py);
         idle(1);
         chk($sformatf("probe%0d", i), 32'(bus.bullet_pix[0]), 32'(probes[i].pix));
      end
      bus.px = 10'd300; bus.py = 10'd300; idle(1);
      bus.px = 10'd0; #1;
      chk("pix_lag_hold", 32'(bus.bullet_pix[0]), 32'd1);
      idle(1);
      chk("pix_lag_drop", 32'(bus.bullet_pix[0]), 32'd0);
      cnt = 0;
      for (int yy = 296; yy < 306; yy++)
         for (int xx = 296; xx < 306; xx++) begin
            bus.px = 10'(xx); bus.py = 10'(yy);
            idle(1);
            cnt += int'(bus.bullet_pix[0]);
         end
      chk("pix_count", 32'(cnt), 32'd4);

      // Mid-frame reset clears outputs without a clock edge.
      bus.px = 10'd300; bus.py = 10'd300; idle(1);
      #2 reset_game = 1'b1;
      #1;
      chk("midrst_active", 32'(bus.active), 32'd0);
      chk("midrst_pix", 32'(bus.bullet_pix), 32'd0);
      chk("midrst_shots", 32'(bus.shots_fired), 32'd0);
      @(posedge clk); #1;
      reset_game = 1'b0;
      model_reset();
      frame(1, '0);
      chk("postrst_active", 32'(bus.active), 32'h1);

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         int j, v;
         if ($urandom_range(0, 5) == 0) bus.fire = ~bus.fire;
         bus.frame_tick = ($urandom_range(0, 9) == 0);
         bus.kill = ($urandom_range(0, 39) == 0) ? 4'($urandom) : 4'b0000;
         if ($urandom_range(0, 7) == 0) begin
            bus.ship_x = 10'($urandom_range(0, H_ACTIVE - 1));
            bus.ship_y = 10'($urandom_range(0, V_ACTIVE - 1));
            bus.ship_dir = 3'($urandom);
         end
         if ($urandom_range(0, 1) == 0) begin
            j = $urandom_range(0, NB - 1);
            v = mx[j] + $urandom_range(0, 3) - 1;
            bus.px = 10'((v < 0) ? 0 : (v > 1023) ? 1023 : v);
            v = my[j] + $urandom_range(0, 3) - 1;
            bus.py = 10'((v < 0) ? 0 : (v > 1023) ? 1023 : v);
         end else begin
            bus.px = 10'($urandom_range(0, H_ACTIVE - 1));
            bus.py = 10'($urandom_range(0, V_ACTIVE - 1));
         end
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bullet_controller.md
# bullet_controller

Owns the ship's bullets: spawns them from the ship on a fire request, advances them once per frame, retires them on lifetime expiry, screen exit or a collision kill, and renders their pixel signals. It sits directly upstream of the collision detector. Its `bullet_pix` drives collision pixel inputs 4:1, and it consumes the detector's per-object reset bits 4:1 as `kill`.

## Interface
- `NUM_BULLETS`, 4, bullet slots; one pixel/kill bit each
- `SPEED`, 4, pixels moved per frame per axis
- `LIFETIME`, 60, frames a bullet lives
- `COOLDOWN`, 8, minimum frames between spawns
- `SIZE`, 2, bullet square edge in pixels
- `H_ACTIVE`, 640 / `V_ACTIVE`, 480, visible area
- `clk` in 1: pixel clock
- `reset_game` in 1: reset, asynchronous, active-high
- `frame_tick` in 1: one-`clk` pulse per frame, at frame start
- `fire` in 1: fire button level, asynchronous to `clk`
- `ship_x` in 10, `ship_y` in 10: ship spawn point
- `ship_dir` in 3: heading; 0=up, then clockwise in 45° steps, 7=up-left
- `px` in 10, `py` in 10: current raster position
- `kill` in NUM_BULLETS: per-slot retire request from the collision detector
- `bullet_pix` out NUM_BULLETS: slot i covers (px,py)
- `active` out NUM_BULLETS: slot i is flying
- `shots_fired` out 16: count of spawned bullets, wraps at 2^16

## Operation
- Reset values:
  - all slots IDLE, x/y/dir/life cleared
  - `active`=0, `bullet_pix`=0, `shots_fired`=0, cooldown=0, pending=0
  - fire synchronizer and edge register cleared
- `fire` handling:
  - passes through a 2-FF synchronizer
  - a rising edge sets `pending`
  - further edges while `pending` is set are absorbed
- Per-slot FSM, IDLE ↔ FLYING:
  - IDLE→FLYING on spawn
  - FLYING→IDLE on kill, lifetime zero, or screen exit
- Frame update, on a `frame_tick` cycle, evaluated in this order:
  1. Every FLYING slot not killed this cycle moves:
     - dx, dy ∈ {−SPEED, 0, +SPEED}, taken from `dir`
     - arithmetic in 11-bit signed
     - life decrements
     - if the new life is 0, or the new x ∉ [0, H_ACTIVE−1] or new y ∉ [0, V_ACTIVE−1], the slot goes IDLE
  2. Cooldown decrements if it is nonzero.
  3. Spawn occurs if `pending` && cooldown==0 && a free slot exists:
     - the lowest-index IDLE slot is used (not killed and not just retired this cycle)
     - the slot loads `ship_x`, `ship_y`, `ship_dir`, life=LIFETIME
     - cooldown=COOLDOWN, `pending` clears, `shots_fired`++
     - no slot free: `pending` is held until one frees up
- Kill:
  - `kill[i]` forces slot i IDLE at the next edge, on any cycle
  - it takes priority over move and over spawn into the same slot
  - a kill on an IDLE slot is ignored
  - a kill applied to all slots is the normal game-reset path
- Render:
  - `bullet_pix[i]` = FLYING && x ≤ px < x+SIZE && y ≤ py < y+SIZE
  - registered
- `reset_game` mid-frame returns everything to the reset values immediately. The first frame after release behaves as from power-up.

## Timing
- `fire` edge to `pending` set: 3 `clk` (2 sync + 1 edge detect).
- Spawn happens on the first eligible `frame_tick`. `active[i]` rises 1 `clk` after that tick.
- `kill[i]` to `active[i]`/`bullet_pix[i]` low: 1 `clk`.
- `bullet_pix` lags (px,py) by 1 `clk`; the downstream detector compensates.
- Position updates only on `frame_tick`, so the render is stable for the whole frame.
- Minimum spawn spacing is COOLDOWN frames.

## Configuration
- `BULLET_WRAP_EN` defined:
  - a screen exit wraps the coordinate: x mod H_ACTIVE, y mod V_ACTIVE, computed from the signed result
  - the slot stays FLYING; only life or kill retires it
- `BULLET_WRAP_EN` undefined: screen exit retires the slot, as in Operation.

## Structure
- Shared package `asteroids_pkg` holds:
  - the slot state enum (IDLE, FLYING)
  - the direction encoding and screen constants H_ACTIVE/V_ACTIVE
  - the direction→(dx,dy) sign lookup
- Sub-module `bullet_slot` holds one slot's FSM, position, life, move/retire/wrap logic and pixel compare. It is instantiated NUM_BULLETS times.
- The top level keeps the synchronizer, pending, cooldown, the free-slot priority encoder and `shots_fired`.

## Test plan
- Spawn: reset, ship=(100,200), dir=2, one fire pulse, one tick → `active`=0001; x=100, y=200; after 5 more ticks x=120; `shots_fired`=1.
- Rate limit: fire pulse on every frame for 20 ticks → spawns only on ticks 1, 9, 17; slots 0,1,2 active; `shots_fired`=3.
- Exhaustion: four spawns, then a fifth fire → `pending` held; `kill`=0001 → the next eligible tick spawns into slot 0.
- Lifetime / exit:
  - dir=0 from y=20 → retires on tick 6 (y<0) without the macro
  - with `BULLET_WRAP_EN`, y becomes 476; retires at tick 60
- Kill vs spawn: `kill[0]` on the same cycle as a `frame_tick` spawn → slot 0 IDLE, spawn goes to slot 1.
- Render / reset: bullet at (300,300), SIZE=2 → `bullet_pix[0]` high for exactly 4 (px,py) points, 1 `clk` late; `reset_game` mid-frame → all outputs 0 at once.
